mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_ram_sp.sv | 29 ++
 rtl/mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, word/address types and fault causes for mem_ctrl.
// Latency: none, types and a pure helper function only.
// Backpressure: none.
package mem_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    // One bit per fault cause so several can be reported together.
    localparam logic [2:0] FAULT_NONE     = 3'b000;
    localparam logic [2:0] FAULT_MISALIGN = 3'b001;
    localparam logic [2:0] FAULT_RANGE    = 3'b010;
    localparam logic [2:0] FAULT_CONFLICT = 3'b100;

    // Classify a request at its sampling edge; aw is the word-address width.
    function automatic logic [2:0] fault_cause(input addr_t addr, input logic rd,
                                               input logic wr, input int aw);
        logic [2:0] cause;
        cause = FAULT_NONE;
        if (addr[1:0] != 2'b00) begin
            cause = cause | FAULT_MISALIGN;
        end
        if ((addr >> (aw + 2)) != '0) begin
            cause = cause | FAULT_RANGE;
        end
        if (rd && wr) begin
            cause = cause | FAULT_CONFLICT;
        end
        return cause;
    endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// mem_ram_sp: single-port 32-bit RAM, 2**ADDR_WIDTH words, no reset on contents.
// Latency: write lands on the clock edge; read data is registered, valid one cycle after addr.
// Backpressure: none, accepts an access every cycle.
module mem_ram_sp
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  word_t                 wdata,
    output word_t                 rdata
);

    word_t mem_q [0:(1 << ADDR_WIDTH) - 1];
    word_t rdata_q;

    // Synchronous write plus registered read of the addressed word (read-before-write).
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: CPU memory controller with wait states, fault detection and optional debug counter (MEM_CTRL_DEBUG_COUNT_EN).
// Latency: mem_ack WAIT_CYCLES+1 cycles after the request is sampled in IDLE, one cycle wide.
// Backpressure: requests are only sampled in IDLE; inputs are ignored during WAIT and ACK.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic        mem_ack,
    output logic [31:0] mem_read_data,
    output logic        mem_error,
    output logic [31:0] debug_count
);

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    word_t                 wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic                  fault_q, fault_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    word_t                 rd_hold_q, rd_hold_d;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    word_t                 ram_wdata;
    word_t                 ram_rdata;

    // Next-state logic: latch the request in IDLE, count wait states, retire in ACK.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        is_wr_d   = is_wr_q;
        fault_d   = fault_q;
        rd_hold_d = rd_hold_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d   = mem_addr[ADDR_WIDTH+1:2];
                    wdata_d = mem_write_data;
                    is_wr_d = mem_write && !mem_read;
                    fault_d = (fault_cause(mem_addr, mem_read, mem_write, ADDR_WIDTH) != FAULT_NONE);
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                // Keep the presented read word (or zero after a fault) until the next one.
                if (fault_q) begin
                    rd_hold_d = '0;
                end else if (!is_wr_q) begin
                    rd_hold_d = ram_rdata;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ack_d = (state_d == S_ACK);
        err_d = ack_d && fault_d;
    end

    // RAM port: in IDLE the live address feeds the RAM so a zero-wait read is ready in ACK.
    always_comb begin
        ram_addr  = (state_q == S_IDLE) ? mem_addr[ADDR_WIDTH+1:2] : idx_q;
        ram_wdata = (state_q == S_IDLE) ? mem_write_data : wdata_q;
        ram_we    = !reset && ack_d && is_wr_d && !fault_d;
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= '0;
            is_wr_q   <= 1'b0;
            fault_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            is_wr_q   <= is_wr_d;
            fault_q   <= fault_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rd_hold_q <= rd_hold_d;
        end
    end

    mem_ram_sp #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign mem_ack       = ack_q;
    assign mem_error     = err_q;
    assign mem_read_data = (ack_q && fault_q)             ? '0        :
                           (ack_q && !is_wr_q)            ? ram_rdata :
                                                            rd_hold_q;

`ifdef MEM_CTRL_DEBUG_COUNT_EN
    word_t dbg_q, dbg_d;

    // Count every completed transaction, faulted ones included, wrapping at 2**32.
    always_comb begin
        dbg_d = dbg_q + (ack_d ? 32'd1 : 32'd0);
    end

    // Debug counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign debug_count = dbg_q;
`else
    assign debug_count = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven, directed and randomized checks of mem_ctrl against a word-array model.
// Latency: expects mem_ack WAIT_CYCLES+1 cycles after the sampling edge.
// Backpressure: one outstanding request at a time, as the controller requires.
module tb_mem_ctrl;

    localparam int WC = 2;
`ifdef MEM_CTRL_DEBUG_COUNT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic        clk;
    logic        reset, mem_read, mem_write, mem_ack, mem_error;
    logic [31:0] mem_addr, mem_write_data, mem_read_data, debug_count;
    logic        rst0, rd0, wr0, ack0, err0;
    logic [31:0] addr0, wdata0, rdata0, dbg0;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: byte-addressed view of a 4 KiB word memory.
    logic [31:0] model_mem [int unsigned];
    logic [31:0] last_rd;
    int          dbg_exp;
    int          ack0_seen = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs [13];

    mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_ack(mem_ack),
        .mem_read_data(mem_read_data), .mem_error(mem_error), .debug_count(debug_count)
    );

    mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(rst0), .mem_read(rd0), .mem_write(wr0),
        .mem_addr(addr0), .mem_write_data(wdata0), .mem_ack(ack0),
        .mem_read_data(rdata0), .mem_error(err0), .debug_count(dbg0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (ack0 === 1'b1) ack0_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected result of one transaction, from the address/operation rules alone.
    task automatic model_txn(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
        err = (addr % 4 != 0) || (addr >= 32'h1000) || (rd && wr);
        if (err) begin
            rdata = 32'h0;
            last_rd = 32'h0;
        end else if (wr) begin
            model_mem[addr / 4] = wdata;
            rdata = last_rd;
        end else begin
            rdata = model_mem.exists(addr / 4) ? model_mem[addr / 4] : 32'hxxxxxxxx;
            last_rd = rdata;
        end
        dbg_exp++;
    endtask

    // One request on dut; inputs turn to garbage after the sampling edge and must be ignored.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata, input string name);
        int lat;
        bit seen;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_write_data = wdata;
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = $urandom; mem_write_data = $urandom;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            if (mem_ack === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check({name, " latency"}, lat, WC + 1);
        if (seen) begin
            check({name, " error"}, {31'b0, mem_error}, {31'b0, exp_err});
            check({name, " rdata"}, mem_read_data, exp_rdata);
            @(negedge clk);
            check({name, " ack one cycle"}, {30'b0, mem_ack, mem_error}, 32'h0);
            check({name, " rdata held"}, mem_read_data, exp_rdata);
        end
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input string name);
        logic        e;
        logic [31:0] r;
        model_txn(rd, wr, addr, wdata, e, r);
        run_txn(rd, wr, addr, wdata, e, r, name);
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        int          acks, consec, lat;
        bit          prev, seen;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h1111_1111};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hAAAA_5555, 1'b0, 32'h1111_1111};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 32'hAAAA_5555};
        vecs[10] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_1002, 32'h0000_0005, 1'b1, 32'h0000_0000};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_write_data = '0;
        rst0 = 1'b1; rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
        last_rd = '0;
        dbg_exp = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0; rst0 = 1'b0;
        @(negedge clk);
        check("reset ack", {31'b0, mem_ack}, 32'h0);
        check("reset error", {31'b0, mem_error}, 32'h0);
        check("reset rdata", mem_read_data, 32'h0);
        check("reset debug_count", debug_count, 32'h0);
        check("reset ack0", {31'b0, ack0}, 32'h0);

        // Directed vectors.
        for (int i = 0; i < 13; i++) begin
            model_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e, r);
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].err, vecs[i].rdata, $sformatf("vec%0d", i));
        end

        // Reset during WAIT of a write aborts it and leaves RAM alone.
        txn(1'b0, 1'b1, 32'h40, 32'h0102_0304, "pre40");
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 32'h40; mem_write_data = 32'hCAFE_F00D;
        @(negedge clk);
        mem_write = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_ack === 1'b1) acks++;
            @(negedge clk);
        end
        check("abort no ack", acks, 0);
        check("abort rdata", mem_read_data, 32'h0);
        check("abort debug_count", debug_count, 32'h0);
        last_rd = '0;
        dbg_exp = 0;

        // Five transactions after reset, one faulted.
        txn(1'b1, 1'b0, 32'h40, 32'h0, "read40");
        txn(1'b0, 1'b1, 32'h44, 32'h0000_0005, "wr44");
        txn(1'b1, 1'b0, 32'h44, 32'h0, "rd44");
        txn(1'b1, 1'b0, 32'h6, 32'h0, "misalign");
        txn(1'b1, 1'b0, 32'h10, 32'h0, "rd10");
        check("debug_count five", debug_count, DBG_EN ? 32'd5 : 32'd0);

        // Randomized traffic over a pool of initialised words.
        for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, "init");
        for (int i = 0; i < 150; i++) begin
            int unsigned k;
            logic        rd, wr;
            logic [31:0] a;
            k = $urandom_range(0, 9);
            a = 32'h100 + 32'($urandom_range(0, 15) * 4);
            rd = (k < 6); wr = !rd;
            if (k == 0) begin
                rd = 1'b1; wr = 1'b1;
            end else if (k == 1) begin
                a = a | 32'($urandom_range(1, 3));
            end else if (k == 2) begin
                a = ($urandom_range(0, 1) == 0) ? (32'h1000 + 32'($urandom_range(0, 255) * 4)) : (a | 32'h4000_0000);
            end
            txn(rd, wr, a, $urandom, "rand");
        end
        check("debug_count final", debug_count, DBG_EN ? 32'(dbg_exp) : 32'd0);

        // Zero wait states with a held request: ack every second cycle.
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'h8;
        acks = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1) begin
                acks++;
                if (prev) consec++;
            end
            prev = (ack0 === 1'b1);
        end
        check("w0 ack count", acks, 6);
        check("w0 no back-to-back", consec, 0);
        check("w0 error", {31'b0, err0}, 32'h0);
        rd0 = 1'b0;
        repeat (2) @(negedge clk);

        // Zero wait states: read right after a write to the same word.
        wr0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h5A5A_1234;
        @(negedge clk);
        check("w0 write ack", {31'b0, ack0}, 32'h1);
        wr0 = 1'b0; rd0 = 1'b1;
        lat = 1; seen = 1'b0;
        while (!seen && lat <= 10) begin
            @(negedge clk);
            if (ack0 === 1'b1) seen = 1'b1;
            else lat++;
        end
        rd0 = 1'b0;
        check("w0 read latency", lat, 2);
        check("w0 read after write", rdata0, 32'h5A5A_1234);
        @(negedge clk);
        check("w0 debug_count", dbg0, DBG_EN ? 32'(ack0_seen) : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
